// File: rtl/updown_seq_ctrl.sv
// updown_seq_ctrl: command sequencer for a WIDTH-bit reversible counter.
// Takes one command (mode, start/end value, pass count) and walks the counter
// through clear, load and stepping, with turn-around in bounce mode, reloads
// between passes, abort handling and a one-cycle done report.
module updown_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             mr,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] start_val,
    input  logic [WIDTH-1:0] end_val,
    input  logic [3:0]       loops,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [3:0]       pass_cnt,
    output logic             wrapped,
    output logic             ctr_mr,
    output logic             ctr_load,
    output logic             ctr_en,
    output logic             ctr_up_down,
    output logic [WIDTH-1:0] ctr_d,
    input  logic [WIDTH-1:0] ctr_q,
    input  logic             ctr_co
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_LOAD,
        S_RUN,
        S_TURN,
        S_FINISH
    } state_t;

    state_t           state;
    logic             bounce_r;
    logic             down_r;
    logic             back_r;
    logic [WIDTH-1:0] start_r;
    logic [WIDTH-1:0] end_r;
    logic [WIDTH-1:0] target_r;
    logic [3:0]       loops_r;
    logic [PW-1:0]    pre_cnt;
    logic             tick;
    logic             at_target;
    logic             last_pass;

    assign tick      = (pre_cnt == '0);
    assign at_target = (ctr_q == target_r);
    assign last_pass = (loops_r != 4'd0) && ((pass_cnt + 4'd1) == loops_r);

    // Counter clear tracks system reset directly so the counter is clean
    // before the first command, and is pulsed for one cycle in CLR.
    assign ctr_mr = ~mr | (state == S_CLR);

    // Stepping stops on the target itself, so the counter never overshoots;
    // abort suppresses the step in the very cycle it is raised.
    assign ctr_en = (state == S_RUN) & tick & ~at_target & ~abort;

    // Sequencer state, prescaler, latched command and registered counter controls.
    always_ff @(posedge clk or negedge mr) begin
        if (!mr) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass_cnt    <= 4'd0;
            wrapped     <= 1'b0;
            ctr_load    <= 1'b1;
            ctr_up_down <= 1'b0;
            ctr_d       <= '0;
            bounce_r    <= 1'b0;
            down_r      <= 1'b0;
            back_r      <= 1'b0;
            start_r     <= '0;
            end_r       <= '0;
            target_r    <= '0;
            loops_r     <= 4'd0;
            pre_cnt     <= '0;
        end else begin
            done     <= 1'b0;
            ctr_load <= 1'b1;

            if (ctr_en && ctr_co)
                wrapped <= 1'b1;

            // Prescaler restarts on every RUN entry so the first RUN cycle ticks.
            if (state == S_RUN)
                pre_cnt <= (pre_cnt == PW'(DIV - 1)) ? '0 : pre_cnt + 1'b1;
            else
                pre_cnt <= '0;

            if (abort && (state != S_IDLE) && (state != S_FINISH)) begin
                state <= S_FINISH;
                done  <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            bounce_r <= (mode == 2'b10);
                            down_r   <= (mode == 2'b01);
                            back_r   <= 1'b0;
                            start_r  <= start_val;
                            end_r    <= end_val;
                            target_r <= end_val;
                            loops_r  <= loops;
                            pass_cnt <= 4'd0;
                            wrapped  <= 1'b0;
                            busy     <= 1'b1;
                            state    <= S_CLR;
                        end
                    end
                    S_CLR: begin
                        ctr_load    <= 1'b0;
                        ctr_d       <= start_r;
                        ctr_up_down <= down_r;
                        state       <= S_LOAD;
                    end
                    S_LOAD: begin
                        state <= S_RUN;
                    end
                    S_RUN: begin
                        if (at_target) begin
                            // Outbound bounce arrival turns without counting a pass;
                            // a degenerate bounce (start == end) has nothing to walk back.
                            if (bounce_r && !back_r && (start_r != end_r)) begin
                                ctr_up_down <= 1'b1;
                                back_r      <= 1'b1;
                                target_r    <= start_r;
                                state       <= S_TURN;
                            end else begin
                                pass_cnt <= pass_cnt + 4'd1;
                                if (last_pass) begin
                                    done  <= 1'b1;
                                    state <= S_FINISH;
                                end else if (bounce_r && back_r) begin
                                    ctr_up_down <= 1'b0;
                                    back_r      <= 1'b0;
                                    target_r    <= end_r;
                                    state       <= S_TURN;
                                end else begin
                                    ctr_load    <= 1'b0;
                                    ctr_d       <= start_r;
                                    ctr_up_down <= down_r;
                                    state       <= S_LOAD;
                                end
                            end
                        end
                    end
                    S_TURN: begin
                        state <= S_RUN;
                    end
                    S_FINISH: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
